uart_packet_tx: RTL and testbench

Packet framer on the user side of the 115 200 Bd UART transmitter. It buffers up to DEPTH payload bytes and sends them as one framed packet: sync byte, destination, length, payload, checksum. Each byte goes through the UART's byte-level send handshake (ipTxData / ipTxSend / opTxBusy). The block drives that handshake the way a host must: byte stable, wait for not-busy, assert send, wait for busy, release send.

---
 rtl/uart_packet_tx.sv | 183 ++++++++++++++++++
 tb/tb_uart_packet_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_tx.sv
// Packet framer in front of a byte-level UART transmitter: buffers payload bytes, then sends
// SYNC, DEST, LEN, payload and a two's-complement checksum through the UART send handshake.
module uart_packet_tx #(
  parameter logic [7:0]  SYNC_BYTE = 8'h55,
  parameter int unsigned DEPTH     = 16
) (
  input  logic       ipClk,
  input  logic       ipReset,
  input  logic [7:0] ipWrData,
  input  logic       ipWrEnable,
  output logic       opFull,
  input  logic [7:0] ipDest,
  input  logic       ipSend,
  output logic       opBusy,
  output logic       opDone,
  output logic [7:0] opTxData,
  output logic       opTxSend,
  input  logic       ipTxBusy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StWaitIdle,
    StSend,
    StRelease,
    StFinish
  } state_e;

  typedef enum logic [2:0] {
    PosSync,
    PosDest,
    PosLen,
    PosPay,
    PosChk
  } pos_e;

  logic [7:0] mem_q [DEPTH];

  state_e        state_q, state_d;
  pos_e          pos_q, pos_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [7:0]    dest_q, dest_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    chk_q, chk_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          full_q, full_d;
  logic          done_q, done_d;

  logic          wr_ok;
  logic          send_ok;
  logic [CW-1:0] count_wr;
  logic [7:0]    cur_byte;

  // A write and a send in the same cycle both take effect; the send sees the new count.
  assign wr_ok    = ipWrEnable && (state_q == StIdle) && !full_q;
  assign count_wr = count_q + CW'(wr_ok);
  assign send_ok  = ipSend && (state_q == StIdle) && (count_wr != '0);

  always_comb begin
    cur_byte = 8'h00;
    unique case (pos_q)
      PosSync: cur_byte = SYNC_BYTE;
      PosDest: cur_byte = dest_q;
      PosLen:  cur_byte = len_q;
      PosPay:  cur_byte = mem_q[idx_q[AW-1:0]];
      PosChk:  cur_byte = ~chk_q + 8'd1;
      default: cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    count_d   = count_q;
    idx_d     = idx_q;
    dest_d    = dest_q;
    len_d     = len_q;
    chk_d     = chk_q;
    tx_data_d = tx_data_q;
    done_d    = 1'b0;

    if (wr_ok) begin
      count_d = count_wr;
    end

    unique case (state_q)
      StIdle: begin
        if (send_ok) begin
          dest_d  = ipDest;
          len_d   = 8'(count_wr);  // DEPTH of 256 wraps to 8'h00
          chk_d   = 8'h00;
          idx_d   = '0;
          pos_d   = PosSync;
          state_d = StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (!ipTxBusy) begin
          tx_data_d = cur_byte;
          if (pos_q == PosDest || pos_q == PosLen || pos_q == PosPay) begin
            chk_d = chk_q + cur_byte;
          end
          state_d = StSend;
        end
      end
      StSend: begin
        if (ipTxBusy) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        state_d = StWaitIdle;
        unique case (pos_q)
          PosSync: pos_d = PosDest;
          PosDest: pos_d = PosLen;
          PosLen:  pos_d = PosPay;
          PosPay: begin
            idx_d = idx_q + CW'(1);
            if (idx_q + CW'(1) == count_q) begin
              pos_d = PosChk;
            end
          end
          PosChk:  state_d = StFinish;
          default: pos_d = PosSync;
        endcase
      end
      StFinish: begin
        if (!ipTxBusy) begin
          done_d  = 1'b1;
          count_d = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    full_d = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state_q   <= StIdle;
      pos_q     <= PosSync;
      count_q   <= '0;
      idx_q     <= '0;
      dest_q    <= 8'h00;
      len_q     <= 8'h00;
      chk_q     <= 8'h00;
      tx_data_q <= 8'h00;
      full_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      dest_q    <= dest_d;
      len_q     <= len_d;
      chk_q     <= chk_d;
      tx_data_q <= tx_data_d;
      full_q    <= full_d;
      done_q    <= done_d;
    end
  end

  // Payload RAM carries no reset; contents are meaningless until rewritten.
  always_ff @(posedge ipClk) begin
    if (wr_ok) begin
      mem_q[count_q[AW-1:0]] <= ipWrData;
    end
  end

  assign opFull   = full_q;
  assign opBusy   = (state_q != StIdle);
  assign opDone   = done_q;
  assign opTxData = tx_data_q;
  assign opTxSend = (state_q == StSend);

endmodule

// File: tb/tb_uart_packet_tx.sv
// Directed and randomized bench for uart_packet_tx with a byte-level UART model and a
// queue-based frame reference model.
module tb_uart_packet_tx;

  localparam int unsigned DEPTH = 16;
  localparam logic [7:0]  SYNC  = 8'h55;

  logic       ipClk;
  logic       ipReset;
  logic [7:0] ipWrData;
  logic       ipWrEnable;
  logic       opFull;
  logic [7:0] ipDest;
  logic       ipSend;
  logic       opBusy;
  logic       opDone;
  logic [7:0] opTxData;
  logic       opTxSend;
  logic       ipTxBusy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_buf[$];
  logic [7:0] exp_frame[$];
  logic [7:0] cap_q[$];
  logic [7:0] last_cap = 8'h00;
  int         busy_cnt = 0;
  int         done_cnt = 0;
  bit         done_prev = 0;
  bit         in_packet = 0;
  bit         stall_first = 0;

  uart_packet_tx #(
    .SYNC_BYTE (SYNC),
    .DEPTH     (DEPTH)
  ) dut (
    .ipClk      (ipClk),
    .ipReset    (ipReset),
    .ipWrData   (ipWrData),
    .ipWrEnable (ipWrEnable),
    .opFull     (opFull),
    .ipDest     (ipDest),
    .ipSend     (ipSend),
    .opBusy     (opBusy),
    .opDone     (opDone),
    .opTxData   (opTxData),
    .opTxSend   (opTxSend),
    .ipTxBusy   (ipTxBusy)
  );

  initial ipClk = 1'b0;
  always #5 ipClk = ~ipClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART model: accepts a byte when send is high and it is idle, then stays busy a while.
  always @(negedge ipClk) begin
    if (!ipReset) begin
      ipTxBusy  = 1'b0;
      busy_cnt  = 0;
      done_prev = 1'b0;
    end else begin
      if (busy_cnt > 0) begin
        check("data_stable_busy", opTxData, last_cap);
        check("send_low_busy", opTxSend, 1'b0);
        busy_cnt--;
        if (busy_cnt == 0) ipTxBusy = 1'b0;
      end else if (opTxSend === 1'b1) begin
        last_cap = opTxData;
        cap_q.push_back(opTxData);
        ipTxBusy = 1'b1;
        if (stall_first && cap_q.size() == 1) begin
          busy_cnt    = 1000;
          stall_first = 1'b0;
        end else begin
          busy_cnt = int'($urandom_range(1, 15));
        end
      end
      if (opDone === 1'b1) begin
        done_cnt++;
        check("done_busy_low", opBusy, 1'b0);
        check("done_one_cycle", done_prev, 1'b0);
      end
      done_prev = opDone;
    end
  end

  task automatic wr(input logic [7:0] b);
    @(posedge ipClk); #1;
    ipWrData   = b;
    ipWrEnable = 1'b1;
    if (!in_packet && exp_buf.size() < DEPTH) exp_buf.push_back(b);
    @(posedge ipClk); #1;
    ipWrEnable = 1'b0;
  endtask

  task automatic start_packet(input logic [7:0] d);
    logic [7:0] sum;
    exp_frame.delete();
    exp_frame.push_back(SYNC);
    exp_frame.push_back(d);
    exp_frame.push_back(8'(exp_buf.size()));
    sum = d + 8'(exp_buf.size());
    foreach (exp_buf[i]) begin
      exp_frame.push_back(exp_buf[i]);
      sum = sum + exp_buf[i];
    end
    exp_frame.push_back(8'h00 - sum);
    cap_q.delete();
    done_cnt = 0;
    @(posedge ipClk); #1;
    ipDest = d;
    ipSend = 1'b1;
    @(posedge ipClk); #1;
    ipSend    = 1'b0;
    in_packet = 1'b1;
    check("busy_after_send", opBusy, 1'b1);
  endtask

  task automatic finish_packet(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 20000) begin
      @(posedge ipClk);
      n++;
    end
    check({tag, "_done_seen"}, (done_cnt != 0), 1'b1);
    repeat (3) @(posedge ipClk);
    #1;
    in_packet = 1'b0;
    exp_buf.delete();
    check({tag, "_frame_len"}, cap_q.size(), exp_frame.size());
    foreach (exp_frame[i]) begin
      check($sformatf("%s_byte%0d", tag, i),
            (i < cap_q.size()) ? {24'h0, cap_q[i]} : 32'hxxxx_xxxx, exp_frame[i]);
    end
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_busy_end"}, opBusy, 1'b0);
    check({tag, "_full_end"}, opFull, 1'b0);
  endtask

  task automatic idle_quiet(input string tag, input int cycles);
    bit bad = 0;
    @(posedge ipClk); #1;
    ipSend = 1'b1;
    @(posedge ipClk); #1;
    ipSend = 1'b0;
    repeat (cycles) begin
      @(posedge ipClk); #1;
      if (opBusy !== 1'b0 || opTxSend !== 1'b0 || opDone !== 1'b0) bad = 1;
    end
    check({tag, "_no_activity"}, bad, 1'b0);
  endtask

  initial begin
    int n;
    int sz;
    bit bad;
    ipReset = 1'b0; ipWrData = 8'h00; ipWrEnable = 1'b0;
    ipDest = 8'h00; ipSend = 1'b0; ipTxBusy = 1'b0;
    repeat (3) @(posedge ipClk);
    #1;
    check("rst_full", opFull, 1'b0);
    check("rst_busy", opBusy, 1'b0);
    check("rst_done", opDone, 1'b0);
    check("rst_txdata", opTxData, 8'h00);
    check("rst_txsend", opTxSend, 1'b0);
    @(posedge ipClk); #1;
    ipReset = 1'b1;

    // Empty send is ignored.
    idle_quiet("empty", 100);
    check("empty_no_bytes", cap_q.size(), 0);

    // Three-byte packet with a known checksum.
    wr(8'h11); wr(8'h22); wr(8'h33);
    start_packet(8'h05);
    finish_packet("three");
    check("three_chk_const", (cap_q.size() == 7) ? {24'h0, cap_q[6]} : 32'hx, 8'h92);

    // Full buffer: the 17th byte is dropped.
    for (int i = 0; i < 16; i++) wr(8'(i));
    check("full_set", opFull, 1'b1);
    wr(8'hFF);
    check("full_held", opFull, 1'b1);
    start_packet(8'hA0);
    finish_packet("full");
    check("full_chk_const", (cap_q.size() == 20) ? {24'h0, cap_q[19]} : 32'hx, 8'hD8);

    // Long UART stall after the sync byte.
    wr(8'h9C); wr(8'h47);
    stall_first = 1'b1;
    start_packet(8'h7E);
    n = 0;
    while (cap_q.size() < 1 && n < 200) begin
      @(posedge ipClk);
      n++;
    end
    bad = 0;
    repeat (900) begin
      @(posedge ipClk); #1;
      if (opTxSend !== 1'b0 || opTxData !== SYNC || cap_q.size() != 1) bad = 1;
    end
    check("stall_hold", bad, 1'b0);
    finish_packet("stall");

    // Write while a packet is in flight is dropped.
    wr(8'hAB); wr(8'hCD);
    start_packet(8'h3C);
    repeat (4) @(posedge ipClk);
    wr(8'hEE);
    finish_packet("midwrite");
    wr(8'h01);
    start_packet(8'h02);
    finish_packet("after_mid");

    // Randomized packets.
    for (int p = 0; p < 4; p++) begin
      n = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < n; i++) wr(8'($urandom));
      start_packet(8'($urandom));
      finish_packet($sformatf("rand%0d", p));
    end

    // Asynchronous reset after the LEN byte.
    wr(8'h5A); wr(8'hA5); wr(8'h3C);
    start_packet(8'h10);
    n = 0;
    while (cap_q.size() < 3 && n < 2000) begin
      @(posedge ipClk);
      n++;
    end
    check("rst_mid_reached_len", (cap_q.size() >= 3), 1'b1);
    #2;
    ipReset = 1'b0;
    #1;
    check("rst_mid_full", opFull, 1'b0);
    check("rst_mid_busy", opBusy, 1'b0);
    check("rst_mid_done", opDone, 1'b0);
    check("rst_mid_txdata", opTxData, 8'h00);
    check("rst_mid_txsend", opTxSend, 1'b0);
    in_packet = 1'b0;
    exp_buf.delete();
    repeat (2) @(posedge ipClk);
    #1;
    ipReset = 1'b1;
    sz = cap_q.size();
    idle_quiet("post_rst", 50);
    check("post_rst_no_bytes", cap_q.size(), sz);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
